disp_chan_sched: RTL and testbench
==================================

# disp_chan_sched

Display-channel scheduler for the eight-channel seven-segment display multiplexer. It drives the multiplexer's 3-bit channel select and its channel-0 latch enable. It either follows a manual switch selection or time-shares the display round-robin among channels that request it, holding each for a fixed dwell. CPU writes to channel 0 are deferred until channel 0 is on screen.

## Interface
- DWELL_CYCLES, 25_000_000: cycles each granted channel stays displayed in auto mode (≥2)
- CNT_W, 25: dwell counter width; must hold DWELL_CYCLES-1
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- auto  in  1  1 = round-robin scan, 0 = manual select
- man_sel  in  3  manual channel number (switches)
- req  in  8  req[i]=1: channel i wants display time; bit 0 = CPU channel
- cpu_wr  in  1  one-cycle pulse: CPU wrote new channel-0 data
- sel  out  3  channel select to multiplexer (registered)
- grant  out  8  one-hot of sel while a channel is held in auto mode, else onehot(sel) in manual, 0 in IDLE
- latch_en  out  1  one-cycle enable to the multiplexer's channel-0 data/blink/point registers
- ack  out  8  ack[i] one-cycle pulse when channel i completes a full dwell
- busy  out  1  1 while in HOLD

## Operation
- States: IDLE, HOLD, MANUAL. All outputs registered.
- Any state, auto=0: next state MANUAL; sel <= man_sel; grant <= onehot(man_sel); cnt <= 0; ack <= 0.
- MANUAL, auto=1: next state IDLE; sel unchanged (round-robin pointer starts from it); grant <= 0.
- Winner search: first i with req[i]=1, scanning (sel+1) mod 8, (sel+2) mod 8 … wrapping, sel itself last. A lone requester is therefore re-granted.
- IDLE, req≠0: sel <= winner, grant <= onehot(winner), cnt <= 0, state HOLD. IDLE, req=0: stay; sel holds.
- HOLD, req[sel]=1 and cnt<DWELL_CYCLES-1: cnt <= cnt+1.
- HOLD, req[sel]=1 and cnt==DWELL_CYCLES-1: ack[sel] <= 1 for one cycle. Then re-arbitrate: with a winner, sel/grant update, cnt <= 0, stay HOLD. With none, grant <= 0 and go IDLE.
- HOLD, req[sel]=0 at any cnt: re-arbitrate the same way next edge, no ack (early release).
- Channel-0 latch, flag pending:
  - MANUAL: latch_en <= cpu_wr; pending <= 0.
  - auto states: let g0 = next-cycle grant[0]. latch_en <= (cpu_wr|pending)&g0; pending <= (cpu_wr|pending)&~g0.
- Only one latch_en pulse per burst; multiple cpu_wr while pending collapse into one.

## Timing
- Reset (async, immediate): sel=0, grant=0, latch_en=0, ack=0, busy=0, cnt=0, pending=0, state IDLE. If auto=0 after release, MANUAL is entered on the first edge.
- Manual select latency: 1 cycle from man_sel to sel.
- Auto: req rising in IDLE at edge t gives sel/grant valid after edge t+1. Each uninterrupted grant lasts exactly DWELL_CYCLES cycles. ack coincides with the first cycle of the next grant.
- auto falling during HOLD: MANUAL next edge, no ack, dwell discarded. pending is cleared by the MANUAL rule.
- cpu_wr in the same cycle as an edge that grants channel 0 produces latch_en on that edge, with no extra delay.
- Counter never exceeds DWELL_CYCLES-1; no wrap-around beyond it.

## Test plan
- Reset mid-HOLD (DWELL_CYCLES=4, req=8'h05): assert rst → all outputs 0 within the same cycle, state IDLE after release.
- Manual: auto=0, man_sel=3'd5 → sel=5, grant=8'h20 one cycle later. cpu_wr pulse → latch_en pulse one cycle later.
- Round-robin, DWELL_CYCLES=4, auto=1, req=8'h85 from IDLE, sel=0 → grants 2,7,0,2… each 4 cycles. ack[2], ack[7], ack[0] each pulse once per dwell.
- Lone requester req=8'h08 → sel=3 continuously, ack[3] every 4 cycles, grant never drops.
- Early release: channel 2 granted, req[2] drops at cnt=1 → next edge grant moves to channel 7, no ack[2].
- Deferred latch: channel 7 displayed, cpu_wr pulsed twice → no latch_en. Exactly one latch_en on the edge granting channel 0; pending then 0.

Source files
------------

// File: rtl/disp_chan_sched_if.sv
// Display-channel scheduler bus.
// Groups the scheduler's control inputs and its registered outputs.
//   auto     : 1 = round-robin scan, 0 = manual select
//   man_sel  : manual channel number
//   req      : per-channel display requests (bit 0 = CPU channel)
//   cpu_wr   : one-cycle pulse, CPU wrote new channel-0 data
//   sel      : channel select to the multiplexer
//   grant    : one-hot of the displayed channel (0 when idle)
//   latch_en : one-cycle channel-0 register load enable
//   ack      : per-channel pulse on completion of a full dwell
//   busy     : a channel is held in auto mode
// master drives the inputs (bench / host), slave is the scheduler.
interface disp_chan_sched_if;
   logic       auto;
   logic [2:0] man_sel;
   logic [7:0] req;
   logic       cpu_wr;
   logic [2:0] sel;
   logic [7:0] grant;
   logic       latch_en;
   logic [7:0] ack;
   logic       busy;

   modport master (
      output auto, man_sel, req, cpu_wr,
      input  sel, grant, latch_en, ack, busy
   );

   modport slave (
      input  auto, man_sel, req, cpu_wr,
      output sel, grant, latch_en, ack, busy
   );
endinterface

// File: rtl/disp_chan_sched.sv
// Display-channel scheduler for the eight-channel seven-segment multiplexer.
// In manual mode the switch value drives the channel select directly. In
// auto mode requesting channels are served round-robin, each held for
// DWELL_CYCLES cycles; a channel that stops requesting is released early.
// CPU writes to channel 0 are deferred until channel 0 is on screen.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : disp_chan_sched_if.slave (see interface header)
// All outputs come straight from flops.
module disp_chan_sched #(
   parameter int DWELL_CYCLES = 25_000_000,
   parameter int CNT_W        = 25
) (
   input  logic                clk,
   input  logic                rst,
   disp_chan_sched_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, HOLD, MANUAL} state_t;

   state_t           state_q, state_d;
   logic [2:0]       sel_q, sel_d;
   logic [7:0]       grant_q, grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       ack_q, ack_d;
   logic             busy_q, busy_d;
   logic             latch_en_q, latch_en_d;
   logic             pending_q, pending_d;

   logic             win_found;
   logic [2:0]       win_idx;
   logic [2:0]       cand;
   logic             dwell_done;
   logic             wr_any;

   // Round-robin search starting just after the current channel; k=8
   // wraps back onto sel itself so a lone requester is re-granted.
   always_comb begin
      win_found = 1'b0;
      win_idx   = sel_q;
      cand      = '0;
      for (int k = 1; k <= 8; k++) begin
         cand = sel_q + 3'(k);
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign dwell_done = (cnt_q == CNT_W'(DWELL_CYCLES - 1));
   assign wr_any     = bus.cpu_wr | pending_q;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      grant_d    = grant_q;
      cnt_d      = cnt_q;
      ack_d      = '0;
      latch_en_d = 1'b0;
      pending_d  = pending_q;

      if (!bus.auto) begin
         state_d = MANUAL;
         sel_d   = bus.man_sel;
         grant_d = 8'b1 << bus.man_sel;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            MANUAL: begin
               // Keep sel so the scan resumes from the last manual channel.
               state_d = IDLE;
               grant_d = '0;
            end
            IDLE: begin
               if (win_found) begin
                  state_d = HOLD;
                  sel_d   = win_idx;
                  grant_d = 8'b1 << win_idx;
                  cnt_d   = '0;
               end
            end
            HOLD: begin
               if (bus.req[sel_q] && !dwell_done) begin
                  cnt_d = cnt_q + 1'b1;
               end else begin
                  // Full dwell earns an ack; early release does not.
                  if (bus.req[sel_q])
                     ack_d = 8'b1 << sel_q;
                  if (win_found) begin
                     sel_d   = win_idx;
                     grant_d = 8'b1 << win_idx;
                     cnt_d   = '0;
                  end else begin
                     state_d = IDLE;
                     grant_d = '0;
                     cnt_d   = '0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Channel-0 load: immediate in manual, otherwise held pending until
      // the edge that puts channel 0 on screen (same-edge writes included).
      if (state_d == MANUAL) begin
         latch_en_d = bus.cpu_wr;
         pending_d  = 1'b0;
      end else begin
         latch_en_d = wr_any & grant_d[0];
         pending_d  = wr_any & ~grant_d[0];
      end

      busy_d = (state_d == HOLD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         grant_q    <= '0;
         cnt_q      <= '0;
         ack_q      <= '0;
         busy_q     <= 1'b0;
         latch_en_q <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         grant_q    <= grant_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
         latch_en_q <= latch_en_d;
         pending_q  <= pending_d;
      end
   end

   assign bus.sel      = sel_q;
   assign bus.grant    = grant_q;
   assign bus.latch_en = latch_en_q;
   assign bus.ack      = ack_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_disp_chan_sched.sv
module tb_disp_chan_sched;

   localparam int DW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   disp_chan_sched_if bus ();

   disp_chan_sched #(.DWELL_CYCLES(DW), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference ----------------
   // Tracks "what is on screen and for how many cycles it has been shown".
   bit       m_manual, m_holding, m_pending;
   int       m_sel, m_shown;
   bit [7:0] m_grant, m_ack;
   bit       m_latch;

   function automatic int m_winner(int s, bit [7:0] r);
      for (int off = 1; off <= 8; off++)
         if (r[(s + off) % 8]) return (s + off) % 8;
      return -1;
   endfunction

   task automatic model_reset();
      m_manual = 0; m_holding = 0; m_pending = 0;
      m_sel = 0; m_shown = 0; m_grant = 0; m_ack = 0; m_latch = 0;
   endtask

   task automatic model_step(input bit a, input int ms, input bit [7:0] r, input bit cw);
      int w;
      m_ack = 0;
      if (!a) begin
         m_manual = 1; m_holding = 0; m_sel = ms; m_grant = 8'(1 << ms);
         m_shown = 0; m_latch = cw; m_pending = 0;
         return;
      end
      if (m_manual) begin
         m_manual = 0; m_grant = 0;
      end else if (!m_holding) begin
         w = m_winner(m_sel, r);
         if (w >= 0) begin
            m_holding = 1; m_sel = w; m_grant = 8'(1 << w); m_shown = 1;
         end
      end else if (r[m_sel] && m_shown < DW) begin
         m_shown++;
      end else begin
         if (r[m_sel]) m_ack = 8'(1 << m_sel);
         w = m_winner(m_sel, r);
         if (w >= 0) begin
            m_sel = w; m_grant = 8'(1 << w); m_shown = 1;
         end else begin
            m_holding = 0; m_grant = 0; m_shown = 0;
         end
      end
      m_latch   = (cw | m_pending) & m_grant[0];
      m_pending = (cw | m_pending) & ~m_grant[0];
   endtask

   // One clock: drive inputs, advance model, sample #1 after the edge and
   // compare the DUT against the model.
   task automatic cycle(input bit a, input int ms, input bit [7:0] r, input bit cw);
      bus.auto = a; bus.man_sel = 3'(ms); bus.req = r; bus.cpu_wr = cw;
      model_step(a, ms, r, cw);
      @(posedge clk);
      #1;
      check("model_sel",   int'(bus.sel),      m_sel);
      check("model_grant", int'(bus.grant),    int'(m_grant));
      check("model_latch", int'(bus.latch_en), int'(m_latch));
      check("model_ack",   int'(bus.ack),      int'(m_ack));
      check("model_busy",  int'(bus.busy),     int'(m_holding));
   endtask

   task automatic do_reset();
      #1 rst = 1'b1;
      model_reset();
      #1;
      check("rst_sel",   int'(bus.sel),      0);
      check("rst_grant", int'(bus.grant),    0);
      check("rst_latch", int'(bus.latch_en), 0);
      check("rst_ack",   int'(bus.ack),      0);
      check("rst_busy",  int'(bus.busy),     0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit       a;
      int       ms;
      bit [7:0] r;
      bit       cw;
      int       e_sel;
      bit [7:0] e_grant;
      bit       e_latch;
      bit [7:0] e_ack;
      bit       e_busy;
   } vec_t;

   vec_t tbl[$];

   initial begin
      bus.auto = 0; bus.man_sel = 0; bus.req = 0; bus.cpu_wr = 0;

      // manual select, immediate latch, then round robin over 0x85 with deferred CPU writes
      tbl.push_back('{0,5,8'h00,0, 5,8'h20,0,8'h00,0});
      tbl.push_back('{0,5,8'h00,1, 5,8'h20,1,8'h00,0});
      tbl.push_back('{0,0,8'h00,0, 0,8'h01,0,8'h00,0});
      tbl.push_back('{1,0,8'h85,0, 0,8'h00,0,8'h00,0});
      tbl.push_back('{1,0,8'h85,0, 2,8'h04,0,8'h00,1});
      tbl.push_back('{1,0,8'h85,0, 2,8'h04,0,8'h00,1});
      tbl.push_back('{1,0,8'h85,0, 2,8'h04,0,8'h00,1});
      tbl.push_back('{1,0,8'h85,0, 2,8'h04,0,8'h00,1});
      tbl.push_back('{1,0,8'h85,0, 7,8'h80,0,8'h04,1});
      tbl.push_back('{1,0,8'h85,1, 7,8'h80,0,8'h00,1});
      tbl.push_back('{1,0,8'h85,1, 7,8'h80,0,8'h00,1});
      tbl.push_back('{1,0,8'h85,0, 7,8'h80,0,8'h00,1});
      tbl.push_back('{1,0,8'h85,0, 0,8'h01,1,8'h80,1});
      tbl.push_back('{1,0,8'h85,0, 0,8'h01,0,8'h00,1});
      tbl.push_back('{1,0,8'h85,1, 0,8'h01,1,8'h00,1});
      tbl.push_back('{1,0,8'h85,0, 0,8'h01,0,8'h00,1});
      tbl.push_back('{1,0,8'h85,0, 2,8'h04,0,8'h01,1});

      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].a, tbl[i].ms, tbl[i].r, tbl[i].cw);
         check($sformatf("tbl%0d_sel", i),   int'(bus.sel),      tbl[i].e_sel);
         check($sformatf("tbl%0d_grant", i), int'(bus.grant),    int'(tbl[i].e_grant));
         check($sformatf("tbl%0d_latch", i), int'(bus.latch_en), int'(tbl[i].e_latch));
         check($sformatf("tbl%0d_ack", i),   int'(bus.ack),      int'(tbl[i].e_ack));
         check($sformatf("tbl%0d_busy", i),  int'(bus.busy),     int'(tbl[i].e_busy));
      end

      // Reset while holding channel 2: outputs clear without a clock edge.
      do_reset();
      cycle(1, 0, 8'h00, 0);
      check("post_rst_idle_grant", int'(bus.grant), 0);
      check("post_rst_idle_busy",  int'(bus.busy),  0);
      cycle(1, 0, 8'h05, 0);
      check("post_rst_grant2", int'(bus.sel), 2);

      // Lone requester: early release of 2 moves to 3, then 3 is re-granted forever.
      cycle(1, 0, 8'h08, 0);
      check("lone_first_sel", int'(bus.sel), 3);
      check("lone_first_ack", int'(bus.ack), 0);
      for (int k = 1; k <= 12; k++) begin
         cycle(1, 0, 8'h08, 0);
         check("lone_sel",   int'(bus.sel),   3);
         check("lone_grant", int'(bus.grant), 8'h08);
         check("lone_ack",   int'(bus.ack),   (k % 4 == 0) ? 8'h08 : 0);
      end

      // Early release: channel 2 drops its request at cnt=1.
      do_reset();
      cycle(1, 0, 8'h85, 0);
      check("er_grant2", int'(bus.grant), 8'h04);
      cycle(1, 0, 8'h85, 0);
      cycle(1, 0, 8'h81, 0);
      check("er_sel7", int'(bus.sel), 7);
      check("er_grant7", int'(bus.grant), 8'h80);
      check("er_no_ack", int'(bus.ack), 0);

      // auto falling during hold: manual next edge, no ack.
      cycle(0, 4, 8'h81, 0);
      check("afall_sel", int'(bus.sel), 4);
      check("afall_ack", int'(bus.ack), 0);
      check("afall_busy", int'(bus.busy), 0);

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         static bit       a  = 1;
         static bit [7:0] r  = 8'h85;
         if ($urandom_range(0, 60) == 0) a = ~a;
         if ($urandom_range(0, 6) == 0) r = 8'($urandom);
         if ($urandom_range(0, 9) == 0) r = 8'h00;
         cycle(a, int'($urandom_range(0, 7)), r, ($urandom_range(0, 7) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
